// File: rtl/azadi_spi_pkg.sv
// rtl/azadi_spi_pkg.sv - shared types and constants for the SPI mode-0 target
package azadi_spi_pkg;

  // Target framing state: idle while deselected, active while CS is low
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  // CPOL/CPHA encoding of the only supported mode
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  // Word shifted out on MISO when software has nothing queued
  localparam logic [7:0] FILL_WORD_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// rtl/spi_target_sync.sv - N-stage synchroniser with a configurable reset value
module spi_target_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with valid/ready RX and holding-register TX
module spi_target
  import azadi_spi_pkg::*;
#(
  parameter int                 DATA_W      = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  FILL_WORD   = DATA_W'(FILL_WORD_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_ni,
  input  logic              sd_i,
  output logic              sd_o,
  output logic              sd_oe,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              overrun_o,
  output logic              underrun_o,
  output logic              frame_err_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sclk_s;
  logic w_cs_s;
  logic w_sd_s;

  spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (sclk_i), .q_o (w_sclk_s)
  );
  spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (cs_ni), .q_o (w_cs_s)
  );
  spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sd (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (sd_i), .q_o (w_sd_s)
  );

  spi_state_e        r_state;
  spi_state_e        w_state_nxt;
  logic              r_sclk_d;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-2:0] r_rx_shift;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_sd_o;
  logic              r_sd_oe;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overrun;
  logic              r_underrun;
  logic              r_frame_err;

  logic              w_enter;
  logic              w_exit;
  logic              w_rise;
  logic              w_fall;
  logic              w_load;
  logic              w_done;
  logic              w_tx_accept;
  logic [DATA_W-1:0] w_next_word;
  logic [DATA_W-1:0] w_rx_word;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the per-cycle strobes that drive the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_exit      = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_cs_s) begin
          w_state_nxt = ST_ACTIVE;
          w_enter     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
          w_exit      = 1'b1;
        end else begin
          w_rise = w_sclk_s & ~r_sclk_d;
          w_fall = ~w_sclk_s & r_sclk_d;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_load      = w_enter | (w_fall & (r_bit_cnt == '0));
    w_done      = w_rise & (r_bit_cnt == LAST_BIT);
    w_next_word = r_hold_full ? r_hold : FILL_WORD;
    w_rx_word   = {r_rx_shift, w_sd_s};
    w_tx_accept = tx_valid_i & ~r_hold_full;
  end

  // Shift engine: bit counter, MOSI deserialiser, MISO serialiser and pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sclk_d    <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_sd_o      <= 1'b0;
      r_sd_oe     <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_d    <= w_sclk_s;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_exit) begin
        r_sd_oe     <= 1'b0;
        r_sd_o      <= 1'b0;
        r_bit_cnt   <= '0;
        r_frame_err <= (r_bit_cnt != '0);
      end
      if (w_enter) begin
        r_sd_oe   <= 1'b1;
        r_bit_cnt <= '0;
      end
      if (w_load) begin
        r_tx_shift <= w_next_word;
        r_sd_o     <= w_next_word[DATA_W-1];
        r_underrun <= ~r_hold_full;
      end else if (w_fall) begin
        r_tx_shift <= r_tx_shift << 1;
        r_sd_o     <= r_tx_shift[DATA_W-2];
      end
      if (w_rise) begin
        r_rx_shift <= w_rx_word[DATA_W-2:0];
        r_bit_cnt  <= w_done ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  // TX holding register; an accept in the same cycle as a load wins the register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_tx_accept) begin
      r_hold      <= tx_data_i;
      r_hold_full <= 1'b1;
    end else if (w_load && r_hold_full) begin
      r_hold_full <= 1'b0;
    end
  end

  // RX output register with sticky overrun when the consumer falls behind
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_done) begin
      if (!r_rx_valid || rx_ready_i) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_rx_valid && rx_ready_i) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign sd_o        = r_sd_o;
  assign sd_oe       = r_sd_oe;
  assign tx_ready_o  = ~r_hold_full;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign overrun_o   = r_overrun;
  assign underrun_o  = r_underrun;
  assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed self-checking bench for spi_target
module tb_spi_target;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       sclk_i = 1'b0;
  logic       cs_ni = 1'b1;
  logic       sd_i = 1'b0;
  logic       sd_o;
  logic       sd_oe;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       overrun_o;
  logic       underrun_o;
  logic       frame_err_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_underrun = 0;
  int n_frame_err = 0;
  logic [7:0] miso;

  spi_target dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sclk_i      (sclk_i),
    .cs_ni       (cs_ni),
    .sd_i        (sd_i),
    .sd_o        (sd_o),
    .sd_oe       (sd_oe),
    .tx_data_i   (tx_data_i),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .overrun_o   (overrun_o),
    .underrun_o  (underrun_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Count high cycles of the single-cycle status pulses
  always @(negedge clk_i) begin
    if (underrun_o === 1'b1) n_underrun++;
    if (frame_err_o === 1'b1) n_frame_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Master side of nbits of one word at clk/8, MSB first; when last is set
  // CS rises together with the final SCLK fall
  task automatic spi_word(input logic [7:0] mosi, input int nbits, input bit last,
                          output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      sd_i = mosi[i];
      idle(4);
      got[i] = sd_o;
      sclk_i = 1'b1;
      idle(4);
      sclk_i = 1'b0;
      if (last && i == 8 - nbits) cs_ni = 1'b1;
    end
  endtask

  task automatic preload(input logic [7:0] d);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    idle(1);
    tx_valid_i = 1'b0;
  endtask

  task automatic rx_accept();
    rx_ready_i = 1'b1;
    idle(1);
    rx_ready_i = 1'b0;
    idle(1);
  endtask

  initial begin
    // 1: reset values
    idle(3);
    check("rst_sd_o", sd_o, 0);
    check("rst_sd_oe", sd_oe, 0);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    rst_ni = 1'b1;
    idle(6);
    check("idle_sd_oe", sd_oe, 0);
    check("idle_tx_ready", tx_ready_o, 1);

    // 2: preloaded A5 out, 3C in, then consumer accepts
    preload(8'hA5);
    check("t2_tx_ready_full", tx_ready_o, 0);
    n_underrun = 0;
    cs_ni = 1'b0;
    spi_word(8'h3C, 8, 1'b1, miso);
    idle(8);
    check("t2_miso", miso, 8'hA5);
    check("t2_rx_data", rx_data_o, 8'h3C);
    check("t2_rx_valid", rx_valid_o, 1);
    check("t2_tx_ready_empty", tx_ready_o, 1);
    check("t2_no_underrun", n_underrun, 0);
    check("t2_sd_oe_off", sd_oe, 0);
    rx_accept();
    check("t2_rx_valid_clr", rx_valid_o, 0);

    // 3: three words without accepting -> first kept, overrun set
    cs_ni = 1'b0;
    spi_word(8'h11, 8, 1'b0, miso);
    check("t3_overrun_w1", overrun_o, 0);
    check("t3_rx_valid_w1", rx_valid_o, 1);
    spi_word(8'h22, 8, 1'b0, miso);
    check("t3_overrun_w2", overrun_o, 1);
    check("t3_rx_data_w2", rx_data_o, 8'h11);
    spi_word(8'h33, 8, 1'b1, miso);
    idle(8);
    check("t3_rx_data_w3", rx_data_o, 8'h11);
    rx_accept();

    // 4: empty holding register -> fill word and one underrun pulse
    n_underrun = 0;
    cs_ni = 1'b0;
    spi_word(8'h96, 8, 1'b1, miso);
    idle(8);
    check("t4_miso_fill", miso, 8'hFF);
    check("t4_underrun_once", n_underrun, 1);
    check("t4_rx_data", rx_data_o, 8'h96);
    rx_accept();
    preload(8'h5A);
    n_underrun = 0;
    cs_ni = 1'b0;
    spi_word(8'h69, 8, 1'b1, miso);
    idle(8);
    check("t4_miso_5a", miso, 8'h5A);
    check("t4_no_underrun", n_underrun, 0);
    rx_accept();

    // 5: CS raised after 5 bits -> frame error, nothing received
    n_frame_err = 0;
    cs_ni = 1'b0;
    spi_word(8'hF0, 5, 1'b1, miso);
    idle(8);
    check("t5_frame_err_once", n_frame_err, 1);
    check("t5_no_rx_valid", rx_valid_o, 0);
    cs_ni = 1'b0;
    spi_word(8'hC3, 8, 1'b1, miso);
    idle(8);
    check("t5_rx_data", rx_data_o, 8'hC3);
    check("t5_rx_valid", rx_valid_o, 1);
    check("t5_no_new_frame_err", n_frame_err, 1);

    // 6: async reset mid-word, then a clean word
    cs_ni = 1'b0;
    spi_word(8'hFF, 3, 1'b0, miso);
    check("t6_sd_oe_before", sd_oe, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_sd_oe", sd_oe, 0);
    check("t6_rst_sd_o", sd_o, 0);
    check("t6_rst_rx_valid", rx_valid_o, 0);
    check("t6_rst_rx_data", rx_data_o, 0);
    check("t6_rst_overrun", overrun_o, 0);
    check("t6_rst_tx_ready", tx_ready_o, 1);
    cs_ni  = 1'b1;
    sclk_i = 1'b0;
    idle(3);
    rst_ni = 1'b1;
    idle(6);
    cs_ni = 1'b0;
    spi_word(8'h81, 8, 1'b1, miso);
    idle(8);
    check("t6_rx_data", rx_data_o, 8'h81);
    check("t6_rx_valid", rx_valid_o, 1);
    check("t6_overrun", overrun_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
